// File: rtl/jtkiwi_pkg.sv
// Shared constants and state encodings for the tile-map scanner.
package jtkiwi_pkg;

  localparam int TILE_W   = 16;
  localparam int MAP_COLS = 32;
  localparam int COL_W    = $clog2(MAP_COLS);
  localparam int TILE_SH  = $clog2(TILE_W);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_CODE = 2'd1,
    F_ATTR = 2'd2,
    F_LAST = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GUARD = 2'd2
  } issue_state_t;

endpackage

// File: rtl/jtkiwi_tilescan_fetch.sv
// VRAM fetch sub-FSM: reads one tile's code and attribute words into the pending registers.
module jtkiwi_tilescan_fetch
  import jtkiwi_pkg::*;
#(
  parameter int VRAM_AW = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               enable,
  input  logic [COL_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  input  logic [15:0]        vram_dout,
  input  logic               take,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               pend_valid,
  output logic [15:0]        pend_code,
  output logic [15:0]        pend_attr,
  output logic               fetched
);

  fetch_state_t st, st_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= F_IDLE;
    else     st <= st_next;
  end

  always_comb begin
    st_next = st;
    case (st)
      F_IDLE:  if (enable && !pend_valid) st_next = F_CODE;
      F_CODE:  st_next = F_ATTR;
      F_ATTR:  st_next = F_LAST;
      F_LAST:  st_next = F_IDLE;
      default: st_next = F_IDLE;
    endcase
    if (abort) st_next = F_IDLE;
  end

  // The attribute address is held through F_LAST so the data bus stays on the same word.
  always_comb begin
    vram_addr = '0;
    case (st)
      F_CODE:         vram_addr = VRAM_AW'({1'b0, row, col});
      F_ATTR, F_LAST: vram_addr = VRAM_AW'({1'b1, row, col});
      default:        vram_addr = '0;
    endcase
  end

  assign fetched = (st == F_LAST) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_code  <= '0;
      pend_attr  <= '0;
    end else begin
      if (st == F_ATTR) pend_code <= vram_dout;
      if (st == F_LAST) pend_attr <= vram_dout;
      // A completing fetch outranks a simultaneous hand-off to the issue side.
      if (abort)        pend_valid <= 1'b0;
      else if (fetched) pend_valid <= 1'b1;
      else if (take)    pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/jtkiwi_tilescan.sv
// Line-start tile scanner: latches scroll, walks NTILES map columns and hands tiles to the draw engine.
module jtkiwi_tilescan
  import jtkiwi_pkg::*;
#(
  parameter int NTILES  = 17,
  parameter int VRAM_AW = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         vrender,
  input  logic [8:0]         hscr,
  input  logic [8:0]         vscr,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [15:0]        vram_dout,
  output logic               draw,
  input  logic               busy,
  output logic [15:0]        code,
  output logic [15:0]        attr,
  output logic [8:0]         xpos,
  output logic [3:0]         ysub,
  output logic               done
);

  localparam int CNT_W = $clog2(NTILES + 1);

  issue_state_t st, st_next;

  logic [COL_W-1:0]   row_reg;
  logic [COL_W-1:0]   col0_reg;
  logic [TILE_SH-1:0] xoff_reg;
  logic [CNT_W-1:0]   nf_reg;
  logic [CNT_W-1:0]   ni_reg;
  logic [8:0]         vy;
  logic [8:0]         xpos_next;
  logic [COL_W-1:0]   col;
  logic               last_tile;
  logic               fetch_en;
  logic               issue_fire;
  logic               pend_valid;
  logic [15:0]        pend_code;
  logic [15:0]        pend_attr;
  logic               fetched;
  logic               unused_bits;

  assign unused_bits = vrender[8];
  assign vy          = {1'b0, vrender[7:0]} + vscr;
  assign col         = col0_reg + COL_W'(nf_reg);
  assign xpos_next   = (9'(ni_reg) << TILE_SH) - 9'(xoff_reg);
  assign last_tile   = (ni_reg == CNT_W'(NTILES));
  assign fetch_en    = (st != S_IDLE) && (nf_reg < CNT_W'(NTILES));

  jtkiwi_tilescan_fetch #(
    .VRAM_AW (VRAM_AW)
  ) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .abort      (start),
    .enable     (fetch_en),
    .row        (row_reg),
    .col        (col),
    .vram_dout  (vram_dout),
    .take       (issue_fire),
    .vram_addr  (vram_addr),
    .pend_valid (pend_valid),
    .pend_code  (pend_code),
    .pend_attr  (pend_attr),
    .fetched    (fetched)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= st_next;
  end

  // GUARD always runs to completion, even across a restart, since busy is not yet valid there.
  always_comb begin
    st_next = st;
    case (st)
      S_IDLE:  if (start) st_next = S_ISSUE;
      S_ISSUE: if (!start && pend_valid && !busy) st_next = S_GUARD;
      S_GUARD: st_next = (!start && last_tile) ? S_IDLE : S_ISSUE;
      default: st_next = S_IDLE;
    endcase
  end

  always_comb begin
    issue_fire = (st == S_ISSUE) && pend_valid && !busy && !start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg  <= '0;
      col0_reg <= '0;
      xoff_reg <= '0;
      nf_reg   <= '0;
      ni_reg   <= '0;
      ysub     <= '0;
      done     <= 1'b1;
      draw     <= 1'b0;
      code     <= '0;
      attr     <= '0;
      xpos     <= '0;
    end else begin
      draw <= issue_fire;
      if (start) begin
        row_reg  <= vy[8:4];
        ysub     <= vy[3:0];
        col0_reg <= hscr[8:4];
        xoff_reg <= hscr[3:0];
        nf_reg   <= '0;
        ni_reg   <= '0;
        done     <= 1'b0;
      end else begin
        if (fetched)                   nf_reg <= nf_reg + CNT_W'(1);
        if (issue_fire)                ni_reg <= ni_reg + CNT_W'(1);
        if (st == S_GUARD && last_tile) done  <= 1'b1;
      end
      if (issue_fire) begin
        code <= pend_code;
        attr <= pend_attr;
        xpos <= xpos_next;
      end
    end
  end

endmodule

// File: doc/jtkiwi_tilescan.md
Name: jtkiwi_tilescan

Overview:
- Tile-map scanner feeding the tile draw engine (`draw`/`busy` handshake, `code`/`attr`/`xpos`/`ysub` bus).
- At each line start it walks the 17 on-screen 16x16 tiles of a 32x32 tile map held in a synchronous VRAM. It fetches code and attribute words, applies scroll, and issues one draw request per tile.
- Prefetches the next tile while the draw engine is busy.

Parameters:
- NTILES, 17, draw requests per line (256 px + one partial tile).
- VRAM_AW, 11, VRAM word address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle line-start pulse; restarts scan
- vrender  in  9  line being prepared (bits [7:0] used)
- hscr  in  9  horizontal scroll
- vscr  in  9  vertical scroll
- vram_addr  out  VRAM_AW  VRAM read address
- vram_dout  in  16  VRAM data; valid exactly 1 cycle after address
- draw  out  1  one-cycle request to draw engine
- busy  in  1  draw engine busy
- code  out  16  tile code, held stable from draw until busy falls
- attr  out  16  tile attribute, same hold rule
- xpos  out  9  tile left pixel in line buffer
- ysub  out  4  row within tile
- done  out  1  high once all NTILES requests accepted for the line

Behaviour:
- Reset: draw=0, done=1, code=0, attr=0, xpos=0, ysub=0, vram_addr=0, FSM=IDLE, pending_valid=0.
- On start:
  - latch vy = vrender[7:0] + vscr (9-bit wrap), giving row = vy[8:4] and ysub = vy[3:0].
  - latch col0 = hscr[8:4] and xoff = hscr[3:0].
  - clear tile counter n=0 and done=0.
- Addressing:
  - code word at {1'b0, row, col}; attr word at {1'b1, row, col}.
  - col = col0 + n, 5-bit wrap (column 31 wraps to 0).
- xpos = {n,4'b0} - xoff, 9-bit wrap. For hscr[3:0]=5, n=0 gives xpos=0x1FB. Negative positions wrap; the line buffer discards them.
- Fetch sub-FSM, one tile per pass:
  - F_CODE drives the code address.
  - F_ATTR drives the attr address and captures code from vram_dout.
  - F_LAST captures attr.
  - Pass result goes to the pending regs (pending_valid=1); 3 cycles per tile.
  - A fetch starts only when pending_valid=0 and fewer than NTILES tiles have been fetched.
- Issue FSM:
  - ISSUE: when pending_valid and !busy, copy pending to the code/attr/xpos outputs, pulse draw for 1 cycle, clear pending_valid, go to GUARD.
  - GUARD: one cycle ignoring busy, because the engine raises busy the cycle after draw. Then return to ISSUE.
  - Outputs must not change while busy=1 or during GUARD. The engine reads attr combinationally throughout the tile.
- done rises the cycle after the NTILES-th draw pulse. It does not wait for the final busy fall.
- Simultaneous pending_valid clear and new fetch completion in the same cycle: the fetch completion wins (pending_valid stays 1).
- start mid-line:
  - abort fetch and discard pending, then recompute per the start rule.
  - No new draw is issued until busy=0 and GUARD has elapsed.
  - The in-flight draw's code/attr stay held until busy falls.
- start during GUARD: GUARD completes first.
- ysub is updated only on start, never mid-line.

Decomposition:
- Shared package (jtkiwi_pkg): TILE_W=16, MAP_COLS=32, fetch state encoding, issue state encoding.
- One natural sub-module: jtkiwi_tilescan_fetch (VRAM fetch sub-FSM plus pending regs). The top holds scroll latching, the issue FSM and counters.

Test Plan:
- hscr=0, vscr=0, vrender=0x10, VRAM code[i]=i, busy model 18 cycles -> 17 draws with xpos 0x000, 0x010 … 0x100; codes 0…16 from addr 0x020…0x030; ysub=0; done after 17th draw.
- hscr=0x1F5, vscr=0x1FC, vrender=0x02 -> row 31, ysub=0xE; columns 31,0,1…15; first xpos=0x1FB, second 0x00B.
- busy held high 100 cycles after first draw -> only one prefetch occurs (3 VRAM reads); code/attr unchanged throughout; second draw pulses exactly 2 cycles after busy falls (ISSUE then draw).
- Busy model that asserts busy only on the cycle after draw -> no double draw pulse in GUARD; exactly one request per tile.
- start pulse at tile 7 while busy=1 -> outputs held until busy falls; next draw carries n=0 tile of the new line; total 17 draws after restart.
- rst asserted mid-line (async, between clock edges) -> draw=0, done=1 immediately; no draw until the next start.
